// File: rtl/hist_avmm_pkg.sv
// hist_avmm_pkg: shared requester IDs, lock states and default widths for the histogram AVMM arbiter.
package hist_avmm_pkg;
  localparam int NUM_REQ = 2;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_MAX_PEND = 4;
  typedef enum logic {REQ_M0 = 1'b0, REQ_M1 = 1'b1} req_id_t;
  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_t;
endpackage

// File: rtl/hist_id_fifo.sv
// hist_id_fifo: in-order FIFO of requester IDs for outstanding reads.
module hist_id_fifo
  import hist_avmm_pkg::*;
#(
  parameter int DEPTH = DEF_MAX_PEND
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  req_id_t                  push_id,
  output req_id_t                  head_id,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  req_id_t mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign head_id = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= push_id;
endmodule

// File: rtl/hist_avmm_arbiter.sv
// hist_avmm_arbiter: two-master Avalon-MM arbiter with grant lock, read-ID tracking and orphan-response detection.
module hist_avmm_arbiter
  import hist_avmm_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int MAX_PEND = DEF_MAX_PEND
) (
  input  logic                        clk_clk,
  input  logic                        clk_reset_reset,
  input  logic [ADDR_W-1:0]           m0_address,
  input  logic                        m0_read,
  input  logic                        m0_write,
  input  logic [DATA_W-1:0]           m0_writedata,
  input  logic [DATA_W/8-1:0]         m0_byteenable,
  output logic                        m0_waitrequest,
  output logic [DATA_W-1:0]           m0_readdata,
  output logic                        m0_readdatavalid,
  input  logic [ADDR_W-1:0]           m1_address,
  input  logic                        m1_read,
  input  logic                        m1_write,
  input  logic [DATA_W-1:0]           m1_writedata,
  input  logic [DATA_W/8-1:0]         m1_byteenable,
  output logic                        m1_waitrequest,
  output logic [DATA_W-1:0]           m1_readdata,
  output logic                        m1_readdatavalid,
  output logic [ADDR_W-1:0]           s_address,
  output logic [DATA_W-1:0]           s_writedata,
  output logic [DATA_W/8-1:0]         s_byteenable,
  output logic                        s_read,
  output logic                        s_write,
  input  logic                        s_waitrequest,
  input  logic [DATA_W-1:0]           s_readdata,
  input  logic                        s_readdatavalid,
  output logic [$clog2(MAX_PEND):0]   pend_count,
  output logic                        orphan_err
);
  lock_t state, state_nx;
  req_id_t last, lock_id, gnt, head;
  logic [NUM_REQ-1:0] rd, act;
  logic g_rd, g_act, fwd, accept, full, empty, pop;
  assign rd = {m1_read, m0_read};
  assign act = rd | {m1_write, m0_write};
  // On a tie the requester not served by the last accepted transfer wins
  always_comb
    gnt = state == LOCKED ? lock_id :
          &act ? (last == REQ_M0 ? REQ_M1 : REQ_M0) :
          act[1] ? REQ_M1 : REQ_M0;
  assign g_rd = rd[gnt];
  assign g_act = act[gnt];
  assign s_read = !clk_reset_reset && g_rd && !full;
  assign s_write = !clk_reset_reset && g_act && !g_rd;
  assign fwd = s_read || s_write;
  assign accept = fwd && !s_waitrequest;
  assign s_address = gnt == REQ_M1 ? m1_address : m0_address;
  assign s_writedata = gnt == REQ_M1 ? m1_writedata : m0_writedata;
  assign s_byteenable = gnt == REQ_M1 ? m1_byteenable : m0_byteenable;
  assign m0_waitrequest = !(accept && gnt == REQ_M0);
  assign m1_waitrequest = !(accept && gnt == REQ_M1);
  assign m0_readdata = s_readdata;
  assign m1_readdata = s_readdata;
  assign pop = !clk_reset_reset && s_readdatavalid && !empty;
  assign m0_readdatavalid = pop && head == REQ_M0;
  assign m1_readdatavalid = pop && head == REQ_M1;
  // A lock is also dropped if the holder withdraws its command
  always_comb
    state_nx = state == UNLOCKED ? (fwd && s_waitrequest ? LOCKED : UNLOCKED)
                                 : (accept || !g_act ? UNLOCKED : LOCKED);
  always_ff @(posedge clk_clk) begin
    if (clk_reset_reset) begin
      state <= UNLOCKED;
      last <= REQ_M1;
      lock_id <= REQ_M0;
      orphan_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == UNLOCKED) lock_id <= gnt;
      if (accept) last <= gnt;
      if (s_readdatavalid && empty) orphan_err <= 1'b1;
    end
  end
  hist_id_fifo #(.DEPTH(MAX_PEND)) u_id_fifo (
    .clk(clk_clk),
    .rst(clk_reset_reset),
    .push(accept && s_read),
    .pop(pop),
    .push_id(gnt),
    .head_id(head),
    .full(full),
    .empty(empty),
    .count(pend_count)
  );
endmodule
